// File: rtl/misr_sig_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : misr_pkg
//  Purpose  : Shared definitions for the MISR signature engine: FSM state
//             encoding, default feedback tap masks for common widths and the
//             pure next-signature function used by the datapath.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package misr_pkg;

  // FSM state encoding, kept as plain constants for legacy tool flows
  localparam int         STATE_W    = 3;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COMPACT = 3'd1;
  localparam logic [2:0] ST_CMP     = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_UNLOAD  = 3'd4;

  // Default tap masks; bit i set means sig[i] contributes to the feedback
  localparam logic [15:0] POLY_16 = 16'hB400;
  localparam logic [31:0] POLY_32 = 32'h8020_0003;
  localparam logic [63:0] POLY_64 = 64'hD800_0000_0000_0000;

  // Widest signature the helper function handles
  localparam int MAX_W = 64;

  // One compaction step. Operands are zero-extended to MAX_W by the caller;
  // only the low 'width' bits of the result are meaningful.
  function automatic logic [MAX_W-1:0] misr_next(
    input logic [MAX_W-1:0] sig,
    input logic [MAX_W-1:0] data,
    input logic [MAX_W-1:0] poly,
    input int               width
  );
    logic [MAX_W-1:0] nxt;
    logic             fb;
    nxt    = '0;
    fb     = ^(sig & poly);
    nxt[0] = fb ^ data[0];
    for (int i = 1; i < MAX_W; i++) begin
      if (i < width) begin
        nxt[i] = sig[i-1] ^ data[i];
      end
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/misr_sig_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : misr_sig_engine_if
//  Purpose  : Data-beat handshake from the circuit under test plus the serial
//             signature unload stream.
//  Signals  : in_valid/in_data (beat offer), in_ready (engine accepts),
//             so/so_valid (serial signature, MSB first)
//  Modports : master - beat source / unload sink, slave - the engine
//  Revision : 1.0 - initial release
// ============================================================================
interface misr_sig_engine_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             so;
  logic             so_valid;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  so,
    input  so_valid
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output so,
    output so_valid
  );
endinterface
`default_nettype wire

// File: rtl/misr_sig_engine_core.sv
`default_nettype none
// ============================================================================
//  Module   : misr_core
//  Purpose  : Signature register with its load / compact / rotate datapath.
//             Control strobes come from the FSM in misr_sig_engine.
//  Ports    : clk, reset_n (sync, active-low)
//             load   - reload SEED (highest priority)
//             step   - compact 'data' into the signature
//             rotate - rotate the signature left by one (serial unload)
//             data   - response word, sig - current signature
//  Revision : 1.0 - initial release
// ============================================================================
module misr_core
  import misr_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h8020_0003),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic             rotate,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] r_sig;
  logic [WIDTH-1:0] w_next;

  // The helper works on MAX_W-bit operands; WIDTH must not exceed MAX_W
  always_comb begin
    w_next = WIDTH'(misr_next(MAX_W'(r_sig), MAX_W'(data), MAX_W'(POLY), WIDTH));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sig <= SEED;
    end else if (load) begin
      r_sig <= SEED;
    end else if (step) begin
      r_sig <= w_next;
    end else if (rotate) begin
      // MSB leaves on 'so' and re-enters at bit 0, so after WIDTH
      // rotations the signature is restored
      r_sig <= {r_sig[WIDTH-2:0], r_sig[WIDTH-1]};
    end
  end

  assign sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/misr_sig_engine.sv
`default_nettype none
// ============================================================================
//  Module   : misr_sig_engine
//  Purpose  : BIST response compactor. Seeds a MISR, compacts a programmed
//             number of beats, compares against a golden signature and can
//             shift the signature out serially.
//  Ports    : clk, reset_n (sync, active-low)
//             start/num_beats - begin compaction (IDLE/DONE only)
//             abort           - back to IDLE from anywhere
//             bus             - beat handshake + serial unload (slave)
//             golden          - expected signature, sampled in CMP
//             unload          - begin serial shift-out from DONE
//             busy/done/pass  - status, signature - current register
//  Revision : 1.0 - initial release
// ============================================================================
module misr_sig_engine
  import misr_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h8020_0003),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int               CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   num_beats,
  misr_sig_engine_if.slave   bus,
  input  logic [WIDTH-1:0]   golden,
  input  logic               unload,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [WIDTH-1:0]   signature
);

  localparam int SHIFT_W = $clog2(WIDTH + 1);

  logic [STATE_W-1:0] r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [SHIFT_W-1:0] r_shift;
  logic               r_pass;

  logic w_idle_or_done;
  logic w_start_ok;
  logic w_accept;
  logic w_load;
  logic w_step;
  logic w_rotate;

  assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_start_ok     = start && w_idle_or_done && !abort;
  assign w_accept       = (r_state == ST_COMPACT) && bus.in_valid;
  assign w_load         = abort || w_start_ok;
  assign w_step         = w_accept && !abort;
  assign w_rotate       = (r_state == ST_UNLOAD) && !abort;

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (w_load),
    .step    (w_step),
    .rotate  (w_rotate),
    .data    (bus.in_data),
    .sig     (signature)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_pass  <= 1'b0;
    end else if (abort) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_pass  <= 1'b0;
    end else if (w_start_ok) begin
      // start outranks unload when both arrive in DONE
      r_cnt   <= num_beats;
      r_pass  <= 1'b0;
      r_state <= (num_beats == '0) ? ST_CMP : ST_COMPACT;
    end else begin
      case (r_state)
        ST_COMPACT: begin
          if (bus.in_valid) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state <= ST_CMP;
            end
          end
        end
        ST_CMP: begin
          r_pass  <= (signature == golden);
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (unload) begin
            r_shift <= SHIFT_W'(WIDTH);
            r_state <= ST_UNLOAD;
          end
        end
        ST_UNLOAD: begin
          r_shift <= r_shift - SHIFT_W'(1);
          if (r_shift == SHIFT_W'(1)) begin
            r_state <= ST_DONE;
          end
        end
        ST_IDLE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // All status outputs decode registered state only
  assign bus.in_ready = (r_state == ST_COMPACT);
  assign bus.so_valid = (r_state == ST_UNLOAD);
  assign bus.so       = (r_state == ST_UNLOAD) && signature[WIDTH-1];
  assign busy         = (r_state == ST_COMPACT) || (r_state == ST_CMP) ||
                        (r_state == ST_UNLOAD);
  assign done         = (r_state == ST_DONE);
  assign pass         = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_misr_sig_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_misr_sig_engine
//  Purpose  : Self-checking bench for misr_sig_engine (WIDTH=4, POLY=1100,
//             SEED=0001, CNT_W=4). Expected results are queued when stimulus
//             is issued and popped by an independent monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_misr_sig_engine;

  localparam int         WIDTH = 4;
  localparam logic [3:0] POLY  = 4'b1100;
  localparam logic [3:0] SEED  = 4'b0001;
  localparam int         CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             unload = 1'b0;
  logic [CNT_W-1:0] num_beats = '0;
  logic [WIDTH-1:0] golden = '0;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH-1:0] signature;

  misr_sig_engine_if #(.WIDTH(WIDTH)) bus ();

  misr_sig_engine #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .num_beats (num_beats),
    .bus       (bus),
    .golden    (golden),
    .unload    (unload),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] sig;
    logic       pass;
  } done_t;

  done_t      done_q[$];
  logic       so_q[$];
  logic [3:0] stim_q[$];
  logic [3:0] m_sig;
  logic       m_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: shift left, the parity of the tapped bits enters at bit 0,
  // then the data word is XORed in.
  function automatic logic [3:0] ref_next(input logic [3:0] s, input logic [3:0] d);
    int fb;
    int v;
    fb = $countones(s & POLY) % 2;
    v  = ((int'(s) * 2) % 16) + fb;
    return 4'(v) ^ d;
  endfunction

  function automatic logic [3:0] ref_final();
    logic [3:0] s;
    s = SEED;
    foreach (stim_q[i]) s = ref_next(s, stim_q[i]);
    return s;
  endfunction

  // Monitor: compares on every done rising edge and every serial bit
  logic  prev_done = 1'b0;
  done_t mon_e;
  logic  mon_b;
  always @(negedge clk) begin
    if (done && !prev_done) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: actual=sig %0h expected=no completion", signature);
      end else begin
        mon_e = done_q.pop_front();
        check("sig_at_done", signature, mon_e.sig);
        check("pass_at_done", pass, mon_e.pass);
      end
    end
    prev_done = done;
    if (bus.so_valid) begin
      if (so_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL so_unexpected: actual=%0b expected=no serial bit", bus.so);
      end else begin
        mon_b = so_q.pop_front();
        check("so_bit", bus.so, mon_b);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compacts stim_q. Stalls of stall_min..stall_max cycles precede every
  // beat after the first. start_mid re-pulses start during COMPACT.
  task automatic run_compaction(input logic [3:0] gold, input int stall_min,
                                input int stall_max, input bit start_mid,
                                input bit with_unload);
    logic [3:0] part;
    done_t      e;
    int         n;
    int         k;
    n      = stim_q.size();
    m_sig  = ref_final();
    m_pass = (gold == m_sig);
    e.sig  = m_sig;
    e.pass = m_pass;
    done_q.push_back(e);
    num_beats = CNT_W'(n);
    golden    = gold;
    start     = 1'b1;
    unload    = with_unload;
    tick();
    start  = 1'b0;
    unload = 1'b0;
    check("so_valid_after_start", bus.so_valid, 1'b0);
    if (n == 0) begin
      check("zero_beats_in_ready", bus.in_ready, 1'b0);
      check("zero_beats_busy_cmp", busy, 1'b1);
      check("zero_beats_sig_seed", signature, SEED);
      tick();
      check("zero_beats_done", done, 1'b1);
      return;
    end
    part = SEED;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        k = $urandom_range(stall_max, stall_min);
        bus.in_valid = 1'b0;
        for (int j = 0; j < k; j++) begin
          tick();
          check("stall_in_ready", bus.in_ready, 1'b1);
          check("stall_sig_hold", signature, part);
        end
      end
      check("in_ready_compact", bus.in_ready, 1'b1);
      if (start_mid && i == 1) begin
        start     = 1'b1;
        num_beats = CNT_W'($urandom_range(0, 15));
      end
      bus.in_valid = 1'b1;
      bus.in_data  = stim_q[i];
      tick();
      start = 1'b0;
      part  = ref_next(part, stim_q[i]);
      check("sig_after_beat", signature, part);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 4'($urandom);
    check("done_latency_cmp", done, 1'b0);
    check("in_ready_cmp", bus.in_ready, 1'b0);
    tick();
    check("done_latency_done", done, 1'b1);
  endtask

  task automatic do_unload(input bit reset_mid);
    done_t e;
    for (int i = WIDTH - 1; i >= 0; i--) so_q.push_back(m_sig[i]);
    if (!reset_mid) begin
      e.sig  = m_sig;
      e.pass = m_pass;
      done_q.push_back(e);
    end
    unload = 1'b1;
    tick();
    unload = 1'b0;
    check("unload_busy", busy, 1'b1);
    check("unload_done_low", done, 1'b0);
    if (reset_mid) begin
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      so_q.delete();
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_done", done, 1'b0);
      check("rst_mid_so_valid", bus.so_valid, 1'b0);
      check("rst_mid_sig", signature, SEED);
      check("rst_mid_pass", pass, 1'b0);
      return;
    end
    repeat (WIDTH - 1) tick();
    check("unload_last_so_valid", bus.so_valid, 1'b1);
    tick();
    check("unload_back_done", done, 1'b1);
    check("unload_sig_restored", signature, m_sig);
    check("unload_pass_kept", pass, m_pass);
    check("unload_so_valid_off", bus.so_valid, 1'b0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) tick();
    check("rst_sig", signature, SEED);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_so", bus.so, 1'b0);
    check("rst_so_valid", bus.so_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    reset_n = 1'b1;
    tick();

    // Three zero beats: 0010, 0100, 1001
    stim_q = {4'b0000, 4'b0000, 4'b0000};
    run_compaction(4'b1001, 0, 0, 1'b0, 1'b0);
    check("tp1_sig", signature, 4'b1001);
    check("tp1_pass", pass, 1'b1);

    // 0001 then 0000 with a 3-cycle stall: 0011, 0110; golden mismatches
    stim_q = {4'b0001, 4'b0000};
    run_compaction(4'b0111, 3, 3, 1'b0, 1'b0);
    check("tp2_sig", signature, 4'b0110);
    check("tp2_pass", pass, 1'b0);

    // Serial unload of 0110 -> 0,1,1,0
    do_unload(1'b0);

    // Zero beats, golden equal to and different from SEED
    stim_q = {};
    run_compaction(SEED, 0, 0, 1'b0, 1'b0);
    check("zero_pass_match", pass, 1'b1);
    run_compaction(SEED ^ 4'b1000, 0, 0, 1'b0, 1'b0);
    check("zero_pass_mismatch", pass, 1'b0);

    // Abort after one beat, with a beat offered in the abort cycle
    num_beats    = 4'd5;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b1010;
    tick();
    check("abort_pre_sig", signature, ref_next(SEED, 4'b1010));
    abort        = 1'b1;
    start        = 1'b1;
    bus.in_data  = 4'b0110;
    tick();
    abort        = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    check("abort_sig", signature, SEED);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_in_ready", bus.in_ready, 1'b0);
    check("abort_so_valid", bus.so_valid, 1'b0);
    check("abort_pass", pass, 1'b0);
    tick();
    check("abort_stays_idle", busy, 1'b0);

    // start during COMPACT is ignored
    stim_q = {4'b0111, 4'b1011, 4'b0010, 4'b1110};
    run_compaction(ref_final(), 1, 2, 1'b1, 1'b0);

    // start together with unload in DONE begins a new compaction
    stim_q = {4'b1100, 4'b0101};
    run_compaction(4'b0000, 0, 1, 1'b0, 1'b1);

    // Largest programmable beat count
    stim_q = {};
    for (int i = 0; i < 15; i++) stim_q.push_back(4'($urandom));
    run_compaction(ref_final(), 0, 1, 1'b0, 1'b0);
    do_unload(1'b0);

    // Randomised runs
    for (int r = 0; r < 12; r++) begin
      logic [3:0] g;
      stim_q = {};
      for (int i = 0; i < int'($urandom_range(0, 6)); i++) stim_q.push_back(4'($urandom));
      g = ($urandom_range(0, 1) == 1) ? ref_final() : 4'($urandom);
      run_compaction(g, 0, 2, 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 1) == 1) do_unload(1'b0);
    end

    // Reset in the middle of an unload
    stim_q = {4'b1001, 4'b0011};
    run_compaction(4'b0101, 0, 0, 1'b0, 1'b0);
    do_unload(1'b1);

    repeat (3) tick();
    check("done_q_drained", done_q.size(), 0);
    check("so_q_drained", so_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/misr_sig_engine.md
Name: misr_sig_engine

Overview:
Parametrised multiple-input signature register with a control FSM for BIST response compaction. It is seeded, compacts a programmed number of valid data beats, and compares the final signature against a golden value. It can then shift the signature out serially to the scan/debug chain. It sits between the circuit-under-test output bus and the BIST controller, one instance per observed bus.

Parameters:
WIDTH, 32, signature/data width in bits (>=3)
POLY, 32'h8020_0003, feedback tap mask; bit i=1 means sig[i] feeds back (x^32+x^22+x^2+x+1 default)
SEED, 1, signature value loaded at reset and on start
CNT_W, 16, width of beat counter

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous, active-low reset
start  in  1  pulse: load SEED and counter, begin compaction (honoured in IDLE/DONE only)
abort  in  1  pulse: return to IDLE from any state, signature reloaded with SEED
num_beats  in  CNT_W  beats to compact, sampled on start
in_valid  in  1  data beat valid
in_data  in  WIDTH  CUT response word
in_ready  out  1  high only in COMPACT
golden  in  WIDTH  expected signature, sampled in CMP
unload  in  1  pulse in DONE: start serial shift-out
so  out  1  serial signature bit, MSB first
so_valid  out  1  high while so is meaningful
busy  out  1  high in COMPACT, CMP, UNLOAD
done  out  1  high in DONE
pass  out  1  sig==golden result, valid while done
signature  out  WIDTH  current signature register

Behaviour:
- One clock, synchronous active-low reset. Reset values: state IDLE, signature=SEED, counter=0, in_ready=0, so=0, so_valid=0, busy=0, done=0, pass=0. Reset mid-operation discards all progress.
- Next-signature function: fb = XOR of (sig & POLY); next[0]=fb^d[0]; next[i]=sig[i-1]^d[i] for i>=1. Signature updates only on an accepted beat (in_valid&in_ready); otherwise it holds.
- FSM states: IDLE, COMPACT, CMP, DONE, UNLOAD.
- IDLE/DONE + start: sig<=SEED, cnt<=num_beats, pass<=0. Next state is COMPACT, or CMP if num_beats==0.
- COMPACT: in_ready=1. On each accepted beat: sig update, cnt-1. If accepted and cnt==1, go to CMP next cycle. in_valid low stalls with no timeout.
- CMP: one cycle; pass<=(sig==golden); go to DONE. done rises 2 cycles after the last beat is accepted.
- DONE: holds signature/pass. unload goes to UNLOAD with a WIDTH-cycle shift counter.
- UNLOAD: each cycle so=sig[WIDTH-1], so_valid=1, sig rotates left by 1. After WIDTH cycles sig equals its pre-unload value; return to DONE; pass is unchanged.
- start in COMPACT/CMP/UNLOAD is ignored.
- abort has priority over start/unload in the same cycle. It goes to IDLE, sig<=SEED, pass<=0, so_valid<=0.
- Simultaneous start+unload in DONE: start wins.
- Counter wraps never: loaded value 2^CNT_W-1 is legal; cnt never decrements below 0.
- No combinational path from in_* to outputs except none; all outputs registered or state-decoded.

Decomposition:
- Package misr_pkg: state enum encoding (IDLE=0, COMPACT=1, CMP=2, DONE=3, UNLOAD=4), default POLY constants per common width (16, 32, 64), and a pure next-signature function taking sig, data, poly.
- One natural sub-module: misr_core. It holds the signature register and the compact/rotate/load datapath, with control strobes from the FSM top.

Test Plan:
- WIDTH=4, POLY=4'b1100, SEED=4'b0001, num_beats=3, data 0,0,0 back-to-back -> sig 0010, 0100, 1001; golden=1001 -> done after 2 cycles, pass=1.
- Same config, beats 0001 then 0000 (num_beats=2), with in_valid low 3 cycles between -> sig 0011 then 0110, held during stall, in_ready stays 1; golden=0111 -> pass=0.
- num_beats=0 start -> CMP next cycle, signature=SEED, pass=(golden==SEED), in_ready never asserted.
- DONE with sig=0110, unload -> so=0,1,1,0 over 4 cycles with so_valid=1; then sig=0110, done=1, pass unchanged.
- abort during COMPACT after 1 beat, and reset_n low mid-UNLOAD -> IDLE, sig=SEED, so_valid=0, busy=0, done=0.
- start asserted during COMPACT and start+unload together in DONE -> first ignored, second starts new compaction.
